// File: rtl/z80_uart_rx.sv
// Z80 I/O-mapped 8N1 UART receiver with 16x oversampling and an 8-deep FIFO.
// Optional registered CTS hysteresis: define Z80_UART_RX_CTS_EN.
module z80_uart_rx #(
  parameter int unsigned BAUD_DIV  = 12,
  parameter logic [7:0]  DATA_PORT = 8'hEF,
  parameter logic [7:0]  STAT_PORT = 8'hEE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq,
  input  logic       rd,
  input  logic [7:0] A,
  inout  wire  [7:0] D,
  input  logic       RX_3V,
  output logic       CTS_5V
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [11:0] div_cnt;
  logic        tick;

  logic       rx_s1;
  logic       rx_s2;
  logic [1:0] fl_cnt;
  logic       idle_ok;
  logic       fall;

  state_t     state;
  logic [3:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       push;
  logic       ferr_ev;

  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       pop;
  logic       acc;
  logic       ovr;
  logic       ferr;

  logic       data_sel;
  logic       stat_sel;
  logic       data_q;
  logic       data_qq;
  logic       stat_q;
  logic       stat_qq;
  logic       pop_req;
  logic       stat_clr;
  logic [7:0] dout;

  assign tick = (div_cnt == 12'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 12'd1;
    end
  end

  // idle_ok only trusts rx_s2 once the reset-forced highs have drained,
  // so a line already low at reset release is not taken as a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      fl_cnt  <= '0;
      idle_ok <= 1'b0;
    end else begin
      rx_s1   <= RX_3V;
      rx_s2   <= rx_s1;
      if (fl_cnt != 2'd2) fl_cnt <= fl_cnt + 2'd1;
      idle_ok <= (fl_cnt == 2'd2) & rx_s2;
    end
  end

  assign fall = idle_ok & ~rx_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      push    <= 1'b0;
      ferr_ev <= 1'b0;
    end else begin
      push    <= 1'b0;
      ferr_ev <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            phase <= '0;
          end
        end
        START: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd7) begin
              phase   <= '0;
              bit_cnt <= '0;
              state   <= rx_s2 ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              shreg   <= {rx_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              push    <= rx_s2;
              ferr_ev <= ~rx_s2;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_sel = ~iorq & ~rd & (A == DATA_PORT);
  assign stat_sel = ~iorq & ~rd & (A == STAT_PORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= 1'b0;
      data_qq <= 1'b0;
      stat_q  <= 1'b0;
      stat_qq <= 1'b0;
    end else begin
      data_q  <= data_sel;
      data_qq <= data_q;
      stat_q  <= stat_sel;
      stat_qq <= stat_q;
    end
  end

  assign pop_req  = data_qq & ~data_q;
  assign stat_clr = stat_qq & ~stat_q;

  assign empty = (count == 4'd0);
  assign full  = (count == 4'd8);
  assign pop   = pop_req & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign acc   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 3'd1;
      if (pop) rd_ptr <= rd_ptr + 3'd1;
      unique case ({acc, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: ;
      endcase
      if (push & full & ~pop) ovr <= 1'b1;
      else if (stat_clr)      ovr <= 1'b0;
      if (ferr_ev)            ferr <= 1'b1;
      else if (stat_clr)      ferr <= 1'b0;
    end
  end

  always_comb begin
    dout = {count, 1'b0, ferr, ovr, ~empty};
    if (data_sel) dout = empty ? 8'h00 : mem[rd_ptr];
  end

  assign D = (data_sel | stat_sel) ? dout : 8'bzzzz_zzzz;

`ifdef Z80_UART_RX_CTS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CTS_5V <= 1'b1;
    end else if (count >= 4'd6) begin
      CTS_5V <= 1'b1;
    end else if (count <= 4'd4) begin
      CTS_5V <= 1'b0;
    end
  end
`else
  assign CTS_5V = ~reset;
`endif

endmodule

// File: tb/tb_z80_uart_rx.sv
// Scoreboard bench for z80_uart_rx: frames driven on RX_3V, bytes
// checked through Z80-style status and data reads.
module tb_z80_uart_rx;

  localparam int BAUD_DIV = 12;
  localparam int BIT = 16 * BAUD_DIV;
  localparam logic [7:0] DP = 8'hEF;
  localparam logic [7:0] SP = 8'hEE;
`ifdef Z80_UART_RX_CTS_EN
  localparam logic CTS_EN = 1'b1;
`else
  localparam logic CTS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iorq = 1'b1;
  logic       rd = 1'b1;
  logic [7:0] A = 8'h00;
  wire  [7:0] D;
  logic       rx = 1'b1;
  logic       cts;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  z80_uart_rx #(
    .BAUD_DIV(BAUD_DIV),
    .DATA_PORT(DP),
    .STAT_PORT(SP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iorq(iorq),
    .rd(rd),
    .A(A),
    .D(D),
    .RX_3V(rx),
    .CTS_5V(cts)
  );

  task automatic hold_line(input logic v, input int cyc);
    rx = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT);
    hold_line(stop_bit, BIT);
    hold_line(1'b1, BIT);
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] d);
    @(negedge clk);
    A = addr;
    iorq = 1'b0;
    rd = 1'b0;
    repeat (2) @(negedge clk);
    d = D;
    iorq = 1'b1;
    rd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (cts !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cts got %b want 1", cts);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (cts !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_cts got %b want 0", cts);
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_status got %h want 00", d);
    end
    io_read(DP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL empty_data got %h want 00", d);
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL empty_pop_status got %h want 00", d);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL single_status got %h want 11", d);
    end
    io_read(DP, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    n_cmp++;
    if (d !== e) begin
      n_bad++;
      $display("FAIL single_data got %h want %h", d, e);
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL single_after got %h want 00", d);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] e;
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b1);
      if (k <= 8) exp_q.push_back(8'(k));
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h83) begin
      n_bad++;
      $display("FAIL ovr_status got %h want 83", d);
    end
    for (int k = 0; k < 8; k++) begin
      io_read(DP, d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      n_cmp++;
      if (d !== e) begin
        n_bad++;
        $display("FAIL ovr_data[%0d] got %h want %h", k, d, e);
      end
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ovr_cleared got %h want 00", d);
    end
  endtask

  task automatic test_ferr();
    logic [7:0] d;
    send_frame(8'hFF, 1'b0);
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h04) begin
      n_bad++;
      $display("FAIL ferr_status got %h want 04", d);
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ferr_cleared got %h want 00", d);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic [7:0] e;
    hold_line(1'b0, 4 * BAUD_DIV);
    hold_line(1'b1, 2 * BIT);
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL glitch_status got %h want 00", d);
    end
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    io_read(DP, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    n_cmp++;
    if (d !== e) begin
      n_bad++;
      $display("FAIL glitch_recover got %h want %h", d, e);
    end
  endtask

  task automatic test_cts();
    logic [7:0] d;
    logic [7:0] e;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1);
      exp_q.push_back(8'h10 + 8'(k));
    end
    n_cmp++;
    if (cts !== 1'b0) begin
      n_bad++;
      $display("FAIL cts_rise5 got %b want 0", cts);
    end
    send_frame(8'h16, 1'b1);
    exp_q.push_back(8'h16);
    n_cmp++;
    if (cts !== CTS_EN) begin
      n_bad++;
      $display("FAIL cts_at6 got %b want %b", cts, CTS_EN);
    end
    for (int k = 0; k < 6; k++) begin
      io_read(DP, d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      n_cmp++;
      if (d !== e) begin
        n_bad++;
        $display("FAIL cts_data[%0d] got %h want %h", k, d, e);
      end
      if (k < 2) begin
        n_cmp++;
        if (cts !== (CTS_EN & (k == 0))) begin
          n_bad++;
          $display("FAIL cts_fall[%0d] got %b want %b", k, cts,
                   CTS_EN & (k == 0));
        end
      end
    end
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL cts_drained got %h want 00", d);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'h77, 1'b1);
    exp_q.push_back(8'h77);
    hold_line(1'b0, 4 * BIT + BIT / 2);
    reset = 1'b0;
    exp_q.delete();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (cts !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_cts got %b want 1", cts);
    end
    reset = 1'b1;
    hold_line(1'b0, BIT / 2 + 4 * BIT - 8);
    hold_line(1'b1, 2 * BIT);
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_status got %h want 00", d);
    end
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    io_read(SP, d);
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL mid_next_status got %h want 11", d);
    end
    io_read(DP, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    n_cmp++;
    if (d !== e) begin
      n_bad++;
      $display("FAIL mid_next_data got %h want %h", d, e);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_ferr();
    test_glitch();
    test_cts();
    test_reset_midframe();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
